uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter: byte FIFO plus a serializer that drives txd.
- Sits between user logic in top and the serial pin, on the serclk domain.
- Accepts bytes on an AXI-stream-style valid/ready input.
- Uses the same prescale convention as the existing UART: one bit time = 8 × prescale clocks.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- PRESCALE_W, 16, width of the prescale input.

Ports:
- clk  input  1  serial clock; all logic on the rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- prescale  input  PRESCALE_W  bit time = 8 × prescale clocks; 0 is treated as 1.
- s_tdata  input  8  byte to send.
- s_tvalid  input  1  s_tdata is valid.
- s_tready  output  1  FIFO not full; push when s_tvalid && s_tready.
- txd  output  1  serial line; idle high.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - txd=1, busy=0, s_tready=1, fifo_count=0.
  - FIFO pointers zeroed, state=IDLE, all counters 0.
- Reset mid-frame: txd returns high immediately and the FIFO is flushed; the partial frame is lost.
- FIFO:
  - Synchronous; push on s_tvalid && s_tready.
  - s_tready = !full and is registered-state derived, with no dependence on s_tvalid.
  - No write-through when full: a simultaneous push and pop while full is impossible because s_tready=0.
  - Simultaneous push and pop when not full or empty leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- Bit timer:
  - Reload value L = 8 × max(prescale,1) − 1, computed at PRESCALE_W+3 bits.
  - prescale is latched at frame start; changes mid-frame take effect on the next frame.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: txd=1. If FIFO non-empty, pop, load the shift register, load the timer with L, go to START. With an empty FIFO, a byte accepted at edge N leaves IDLE at edge N+1, so txd falls at edge N+1.
  - START: txd=0 for L+1 cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first, L+1 cycles per bit. After bit 7, go to STOP.
  - STOP: txd=1 for L+1 cycles. On the last STOP cycle:
    - if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with zero idle gap;
    - otherwise go to IDLE.
- Frame length: exactly 10 × (L+1) clocks.
- txd is a registered output, glitch-free.
- busy = (state != IDLE) || !empty.
- s_tvalid deasserting without a handshake has no effect; s_tdata is sampled only on the handshake.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, STOP};
  - DATA_BITS=8;
  - OVERSAMPLE=8;
  - STOP_BITS=1.
- One natural sub-module: byte_fifo, a parameterized synchronous FIFO providing push/pop/full/empty/count. The serializer FSM stays in uart_tx_buffered.

Test Plan:
1. Single byte, prescale=4: push 0x55 at edge N.
   - txd falls at edge N+1.
   - Bit sequence 0,1,0,1,0,1,0,1,0,1, each bit held 32 clocks.
   - Line idle high after 320 clocks; busy falls at the same time.
2. Back-to-back frames, prescale=4: push 0xA3 then 0x0F on consecutive cycles.
   - Second start bit begins the cycle immediately after the first stop bit ends.
   - Total busy time 640 clocks.
   - Decoded bytes are 0xA3 then 0x0F.
3. Full FIFO, DEPTH=8, s_tvalid held high with 10 bytes queued.
   - 9 bytes accepted: the first is popped immediately, then 8 are buffered.
   - s_tready goes low and fifo_count=8.
   - The 10th byte is accepted only on the cycle after the pop at the end of frame 1 (clock 320 of frame 1).
4. prescale=0: push 0xFF.
   - Every bit is 8 clocks; frame length 80 clocks.
   - prescale changed 0→10 mid-frame does not alter the current frame.
   - The next frame uses 80-clock bits.
5. Reset mid-frame, prescale=4: assert n_rst low at clock 100 of a frame, with 3 bytes queued.
   - txd=1, s_tready=1, fifo_count=0, busy=0 asynchronously.
   - After release, no transmission occurs until a new push.
6. Simultaneous push/pop: push a byte on the exact cycle STOP→START pops.
   - fifo_count is unchanged.
   - The pushed byte is sent in the following frame, preserving order.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter.
//   tx_state_t  : serializer states (IDLE, START, DATA, STOP)
//   DATA_BITS   : payload bits per frame
//   OVERSAMPLE  : clocks per bit for each unit of prescale
//   STOP_BITS   : stop bits per frame
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 8;
    localparam int STOP_BITS  = 1;

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous FIFO with registered occupancy count.
//   clk    : clock, rising edge
//   n_rst  : asynchronous active-low reset (flushes pointers and count)
//   push   : write wdata when not full
//   wdata  : data to write
//   pop    : advance read pointer when not empty
//   rdata  : entry at the head of the FIFO (valid when !empty)
//   full   : count == DEPTH
//   empty  : count == 0
//   count  : current occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Guard both operations here so a caller can never overflow or
    // underflow the storage, whatever it drives on push/pop.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. A push and pop in the same cycle
    // move both pointers but leave the count where it was.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage itself needs no reset: resetting the pointers empties the FIFO.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 UART transmitter: a byte FIFO feeding a serializer.
//   clk        : serial clock, all logic on the rising edge
//   n_rst      : asynchronous active-low reset
//   prescale   : one bit time = 8 * prescale clocks (0 behaves as 1)
//   s_tdata    : byte to send
//   s_tvalid   : s_tdata is valid
//   s_tready   : FIFO not full; a byte is taken when s_tvalid && s_tready
//   txd        : serial line, idle high, driven straight from a flop
//   busy       : a frame is in progress or bytes are waiting
//   fifo_count : current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [PRESCALE_W-1:0]  prescale,
    input  logic [7:0]             s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic                   txd,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int TW = PRESCALE_W + 3;

    tx_state_t              state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [TW-1:0]          reload_q, reload_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [3:0]             bit_q, bit_d;
    logic                   txd_q, txd_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [7:0]             fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [PRESCALE_W-1:0]  prescale_eff;
    logic [TW-1:0]          reload_calc;
    logic                   bit_done;

    assign s_tready  = !fifo_full;
    assign fifo_push = s_tvalid && s_tready;

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (fifo_push),
        .wdata (s_tdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Timer reload for one bit: 8 * max(prescale,1) - 1, wide enough that
    // the largest prescale cannot overflow. Only captured when a frame
    // starts, so prescale may change freely mid-frame.
    assign prescale_eff = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    assign reload_calc  = TW'(prescale_eff) * TW'(OVERSAMPLE) - TW'(1);
    assign bit_done     = (timer_q == '0);

    // State register. txd is registered alongside the state so the pin
    // never glitches and is forced high the moment reset asserts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            reload_q <= '0;
            shift_q  <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            reload_q <= reload_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            txd_q    <= txd_d;
        end
    end

    // Next-state logic. Every bit (start, data, stop) lasts reload+1 clocks:
    // the timer counts down to zero and the transition happens on the zero
    // cycle. On the last stop cycle a waiting byte is popped and the next
    // start bit begins immediately, so queued frames run with no idle gap.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        reload_d = reload_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    reload_d = reload_calc;
                    timer_d  = reload_calc;
                    bit_d    = '0;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_done) begin
                    timer_d = reload_q;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    timer_d = reload_q;
                    shift_d = shift_q >> 1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            reload_d = reload_calc;
                            timer_d  = reload_calc;
                            state_d  = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        timer_d = reload_q;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. The line level is decided from where the FSM is going,
    // so the registered txd changes on the same edge as the state.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign txd  = txd_q;
    assign busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Self-checking bench for uart_tx_buffered. A frame-level model (a byte
// queue plus the position inside the frame currently on the line) predicts
// txd, busy, s_tready and fifo_count every cycle; directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int DEPTH      = 8;
    localparam int PRESCALE_W = 16;

    logic                   clk;
    logic                   n_rst;
    logic [PRESCALE_W-1:0]  prescale;
    logic [7:0]             s_tdata;
    logic                   s_tvalid;
    logic                   s_tready;
    logic                   txd;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state: bytes accepted but not yet on the line, and the frame
    // currently being sent (its byte, bit length and clock position).
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    int         m_bitlen = 8;
    logic [7:0] m_byte   = 8'h00;
    int         cyc      = 0;
    int         last_acc_cyc = 0;

    uart_tx_buffered #(
        .DEPTH      (DEPTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .prescale   (prescale),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // 100 MHz serial clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single place where a comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected line level: frame bit index = position / bit length,
    // bit 0 is the start bit, 1..8 the data LSB first, 9 the stop bit.
    function automatic logic model_txd();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / m_bitlen;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    // Behavioural model, stepped on every rising edge. Acceptance uses the
    // occupancy before the edge; a finished frame hands the line straight to
    // the next queued byte; the bit length is taken from prescale at the
    // moment a frame starts.
    initial begin
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                mq.delete();
                m_active = 1'b0;
                m_pos    = 0;
            end else begin
                bit acc;
                cyc++;
                acc = s_tvalid && (mq.size() < DEPTH);
                if (m_active) begin
                    m_pos++;
                    if (m_pos == 10 * m_bitlen) m_active = 1'b0;
                end
                if (!m_active && mq.size() > 0) begin
                    m_byte   = mq.pop_front();
                    m_bitlen = 8 * ((prescale == 0) ? 1 : int'(prescale));
                    m_pos    = 0;
                    m_active = 1'b1;
                end
                if (acc) begin
                    mq.push_back(s_tdata);
                    last_acc_cyc = cyc;
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst) begin
                checkOutput("txd",        32'(txd),        32'(model_txd()));
                checkOutput("busy",       32'(busy),       32'(m_active || (mq.size() > 0)));
                checkOutput("s_tready",   32'(s_tready),   32'(mq.size() < DEPTH));
                checkOutput("fifo_count", 32'(fifo_count), 32'(mq.size()));
            end
        end
    end

    // Offer one byte; called and returning on a falling edge. The byte is
    // taken on the rising edge after s_tready is seen high.
    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = b;
        while (!s_tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) checkOutput("ready_timeout", 32'(s_tready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    // Wait for the line to go low, then sample mid-bit for nbits bits and
    // count clocks until busy drops. lead = falling edges waited first.
    task automatic captureFrames(input int bitlen, input int nbits,
                                 output logic [19:0] bits, output int busy_len,
                                 output int lead);
        int t = 0;
        bits = '0;
        lead = 0;
        while (txd !== 1'b0 && lead < 2000) begin
            @(negedge clk);
            lead++;
        end
        while (busy === 1'b1 && t < 5000) begin
            for (int i = 0; i < nbits; i++) begin
                if (t == bitlen / 2 + i * bitlen) bits[i] = txd;
            end
            @(negedge clk);
            t++;
        end
        busy_len = t;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    logic [19:0] cap_bits;
    logic [19:0] exp_bits;
    int          cap_len;
    int          cap_lead;
    int          first_cyc;
    int          guard;
    int          lows;
    int          busy_hi;
    bit          found;

    initial begin
        n_rst    = 1'b0;
        prescale = 16'd4;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_txd",        32'(txd),        32'd1);
        checkOutput("rst_busy",       32'(busy),       32'd0);
        checkOutput("rst_ready",      32'(s_tready),   32'd1);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0x55 at prescale 4: 32-clock bits, 320-clock frame.
        $display("[TB] single byte");
        applyStimulus(8'h55);
        captureFrames(32, 10, cap_bits, cap_len, cap_lead);
        exp_bits = {10'b0, 1'b1, 8'h55, 1'b0};
        checkOutput("t1_lead",  32'(cap_lead), 32'd1);
        checkOutput("t1_bits",  32'(cap_bits), 32'(exp_bits));
        checkOutput("t1_len",   32'(cap_len),  32'd320);
        repeat (5) @(negedge clk);

        // Back-to-back 0xA3, 0x0F: 640 busy clocks, no gap between frames.
        $display("[TB] back-to-back");
        applyStimulus(8'hA3);
        applyStimulus(8'h0F);
        captureFrames(32, 20, cap_bits, cap_len, cap_lead);
        exp_bits = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
        checkOutput("t2_lead", 32'(cap_lead), 32'd0);
        checkOutput("t2_bits", 32'(cap_bits), 32'(exp_bits));
        checkOutput("t2_len",  32'(cap_len),  32'd640);
        repeat (5) @(negedge clk);

        // Fill the FIFO: 9 accepted, then the 10th waits for the frame-end pop.
        $display("[TB] full fifo");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(8'h10 + 8'(k));
            if (k == 0) first_cyc = last_acc_cyc;
        end
        checkOutput("t3_full_count", 32'(fifo_count), 32'd8);
        checkOutput("t3_full_ready", 32'(s_tready),   32'd0);
        applyStimulus(8'h19);
        checkOutput("t3_tenth_delay", 32'(last_acc_cyc - first_cyc), 32'd322);
        waitIdle(5000);
        repeat (5) @(negedge clk);

        // prescale 0 acts as 1; a mid-frame change applies to the next frame.
        $display("[TB] prescale zero");
        prescale = 16'd0;
        applyStimulus(8'hFF);
        fork
            captureFrames(8, 10, cap_bits, cap_len, cap_lead);
            begin
                repeat (30) @(negedge clk);
                prescale = 16'd10;
            end
        join
        exp_bits = {10'b0, 1'b1, 8'hFF, 1'b0};
        checkOutput("t4_bits", 32'(cap_bits), 32'(exp_bits));
        checkOutput("t4_len",  32'(cap_len),  32'd80);
        applyStimulus(8'hFF);
        captureFrames(80, 10, cap_bits, cap_len, cap_lead);
        checkOutput("t4_next_bits", 32'(cap_bits), 32'(exp_bits));
        checkOutput("t4_next_len",  32'(cap_len),  32'd800);
        repeat (5) @(negedge clk);

        // Reset at clock 100 of a frame with 3 bytes queued.
        $display("[TB] reset mid-frame");
        prescale = 16'd4;
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        applyStimulus(8'h04);
        guard = 0;
        while (!(m_active && m_pos == 100) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("t5_queued", 32'(fifo_count), 32'd3);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("t5_txd",   32'(txd),        32'd1);
        checkOutput("t5_ready", 32'(s_tready),   32'd1);
        checkOutput("t5_count", 32'(fifo_count), 32'd0);
        checkOutput("t5_busy",  32'(busy),       32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        lows = 0;
        busy_hi = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!txd) lows++;
            if (busy) busy_hi++;
        end
        checkOutput("t5_quiet_txd",  32'(lows),    32'd0);
        checkOutput("t5_quiet_busy", 32'(busy_hi), 32'd0);

        // Push on the exact edge where STOP hands over to the next START.
        $display("[TB] push on pop edge");
        applyStimulus(8'h3C);
        applyStimulus(8'hC3);
        guard = 0;
        found = 1'b0;
        while (!found && guard < 1000) begin
            @(negedge clk);
            guard++;
            found = m_active && (m_pos == 10 * m_bitlen - 1) && (m_byte == 8'h3C);
        end
        checkOutput("t6_reached", 32'(found), 32'd1);
        checkOutput("t6_count_before", 32'(fifo_count), 32'd1);
        s_tvalid = 1'b1;
        s_tdata  = 8'h96;
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
        checkOutput("t6_count_after", 32'(fifo_count), 32'd1);
        checkOutput("t6_next_start",  32'(txd),        32'd0);
        waitIdle(2000);

        // Random traffic with short bit times and occasional prescale changes.
        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            s_tvalid = ($urandom_range(0, 2) == 0);
            s_tdata  = 8'($urandom);
            if ($urandom_range(0, 99) == 0) prescale = 16'($urandom_range(0, 2));
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        waitIdle(6000);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
